// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake from a producer into the UART transmitter.
// Master drives data/valid, slave returns ready.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter behind a small FIFO; tx falls one clk after a push into an idle, empty FIFO.
// tx_ready is !full from the registered count; a pop does not free a slot in the same cycle.
module uart_tx #(
   parameter int CLKS_PER_BIT = 32,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   uart_tx_if.slave                    s_in,
   output logic                        o_tx,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t               r_state;
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0]        r_baud_cnt;
   logic [2:0]           r_bit_idx;
   logic                 r_tx;

   logic w_full;
   logic w_has_data;
   logic w_push;
   logic w_pop;
   logic w_baud_end;

   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_has_data   = (r_count != '0);
   assign w_push       = s_in.tx_valid && !w_full;
   assign w_baud_end   = (r_baud_cnt == BW'(CLKS_PER_BIT - 1));
   // The FSM takes the FIFO head when leaving IDLE or at the end of a stop bit.
   assign w_pop        = w_has_data && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

   assign s_in.tx_ready = !w_full;
   assign o_tx          = r_tx;
   assign o_busy        = (r_state != S_IDLE) || w_has_data;
   assign o_fifo_count  = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_in.tx_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_shift    <= '0;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx       <= 1'b1;
               r_baud_cnt <= '0;
               if (w_has_data) begin
                  r_shift <= r_mem[r_rd_ptr];
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  r_tx       <= r_shift[0];
                  r_bit_idx  <= '0;
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  // Chain straight into the next start bit when more data is queued.
                  if (w_has_data) begin
                     r_shift <= r_mem[r_rd_ptr];
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a line-level frame decoder checks every bit period
// and the FIFO-level outputs against expectations derived from accepted bytes.
module tb_uart_tx;
   localparam int CPB   = 32;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   uart_tx_if #(.DATA_BITS(8)) u_if ();

   uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .s_in        (u_if),
      .o_tx        (tx),
      .o_busy      (busy),
      .o_fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];
   int         acc_n   = 0;
   int         start_n = 0;
   int         max_cnt = 0;

   int    inv_err = 0;
   string inv_what;
   int    inv_act, inv_exp, inv_cyc;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_inv(input string what, input int act, input int exp);
      if (inv_err == 0) begin
         inv_what = what;
         inv_act  = act;
         inv_exp  = exp;
         inv_cyc  = cyc;
      end
      inv_err++;
   endtask

   task automatic flush_inv(input string name);
      checks++;
      if (inv_err != 0) begin
         errors++;
         $display("FAIL invariants_%s: %0d bad cycles, first %s got %0d expected %0d at cycle %0d",
                  name, inv_err, inv_what, inv_act, inv_exp, inv_cyc);
      end
      inv_err = 0;
   endtask

   // Ideal line level at offset c cycles into a frame carrying byte b.
   function automatic logic line_level(input logic [7:0] b, input int c);
      int k;
      k = c / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   // Monitor: detects start bits, decodes frames, checks every cycle of the waveform.
   logic       mon_act = 1'b0;
   logic       mon_have = 1'b0;
   int         mon_cnt = 0;
   int         mon_wave_err = 0;
   logic [7:0] mon_exp = 8'h00;
   logic [7:0] mon_rx = 8'h00;

   always @(negedge clk) begin
      int e_cnt;
      int k;
      if (!rst_n) begin
         mon_act = 1'b0;
         mon_cnt = 0;
         start_n = 0;
      end else begin
         if (!mon_act && tx == 1'b0) begin
            mon_act      = 1'b1;
            mon_cnt      = 0;
            mon_wave_err = 0;
            mon_rx       = 8'h00;
            start_n++;
            start_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               mon_have = 1'b0;
               chk("unexpected_frame_queue_size", 0, 1);
            end else begin
               mon_have = 1'b1;
               mon_exp  = exp_q[0];
            end
         end
         e_cnt = acc_n - start_n;
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (int'(fifo_count) != e_cnt) note_inv("fifo_count", int'(fifo_count), e_cnt);
         if (u_if.tx_ready !== (e_cnt < DEPTH)) note_inv("tx_ready", int'(u_if.tx_ready), int'(e_cnt < DEPTH));
         if (busy !== (mon_act || e_cnt != 0)) note_inv("busy", int'(busy), int'(mon_act || e_cnt != 0));
         if (mon_act) begin
            if (mon_have && tx !== line_level(mon_exp, mon_cnt)) mon_wave_err++;
            k = mon_cnt / CPB;
            if ((mon_cnt % CPB) == CPB / 2 && k >= 1 && k <= 8) mon_rx[k-1] = tx;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
               if (mon_have) begin
                  void'(exp_q.pop_front());
                  chk("frame_data", int'(mon_rx), int'(mon_exp));
                  chk("frame_wave_bad_cycles", mon_wave_err, 0);
               end
               mon_act = 1'b0;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b, output int acc_cyc);
      logic got;
      logic done;
      done    = 1'b0;
      acc_cyc = -1;
      @(negedge clk);
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = b;
      for (int t = 0; t < 3000 && !done; t++) begin
         got = u_if.tx_ready;
         @(posedge clk);
         #1;
         if (got) begin
            acc_n++;
            exp_q.push_back(b);
            acc_cyc = cyc;
            done    = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      u_if.tx_valid = 1'b0;
      if (!done) chk("push_accepted", 0, 1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int t = 0; t < budget; t++) begin
         @(posedge clk);
         #1;
         if (!busy) break;
      end
      chk(name, int'(busy), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected below %0d", cyc, 90000);
      $fatal(1);
   end

   initial begin
      int ac;
      int ac6;
      rst_n         = 1'b0;
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", int'(tx), 1);
      chk("reset_ready", int'(u_if.tx_ready), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_count", int'(fifo_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single 0x55 frame and its exact timing.
      start_q.delete();
      push(8'h55, ac);
      chk("t1_count_after_push", int'(fifo_count), 1);
      chk("t1_tx_high_after_push", int'(tx), 1);
      @(posedge clk);
      #1;
      chk("t1_tx_low_next_edge", int'(tx), 0);
      chk("t1_count_after_pop", int'(fifo_count), 0);
      wait_idle(FRAME + 50, "t1_idle");
      chk("t1_frames", start_q.size(), 1);
      if (start_q.size() >= 1) chk("t1_busy_drop_cycles", cyc - start_q[0], FRAME);
      flush_inv("t1");

      // Back-to-back frames.
      start_q.delete();
      push(8'hA3, ac);
      push(8'h0F, ac);
      wait_idle(2 * FRAME + 50, "t2_idle");
      chk("t2_frames", start_q.size(), 2);
      if (start_q.size() >= 2) chk("t2_frame_gap", start_q[1] - start_q[0], FRAME);
      flush_inv("t2");

      // Fill to capacity; the sixth byte waits for the second frame to start.
      start_q.delete();
      max_cnt = 0;
      ac6     = -1;
      for (int i = 0; i < 6; i++) begin
         push(8'h31 + 8'(i * 17), ac);
         if (i == 4) begin
            chk("t3_ready_when_full", int'(u_if.tx_ready), 0);
            chk("t3_count_when_full", int'(fifo_count), DEPTH);
         end
         if (i == 5) ac6 = ac;
      end
      wait_idle(7 * FRAME, "t3_idle");
      chk("t3_frames", start_q.size(), 6);
      if (start_q.size() >= 2) chk("t6_accept_after_pop", ac6 - start_q[1], 1);
      chk("t6_max_count_le_depth", int'(max_cnt <= DEPTH), 1);
      flush_inv("t3");

      // Reset in the middle of the data bits of 0xF0.
      push(8'hF0, ac);
      repeat (CPB * 4 + CPB / 2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      acc_n = 0;
      exp_q.delete();
      #1;
      chk("t4_tx_at_reset", int'(tx), 1);
      chk("t4_count_at_reset", int'(fifo_count), 0);
      chk("t4_busy_at_reset", int'(busy), 0);
      chk("t4_ready_at_reset", int'(u_if.tx_ready), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_tx_held_in_reset", int'(tx), 1);
      @(negedge clk);
      rst_n = 1'b1;
      flush_inv("t4_pre");
      push(8'h3C, ac);
      wait_idle(FRAME + 50, "t4_idle");
      flush_inv("t4");

      // The 0xD5 loopback pattern.
      push(8'hD5, ac);
      wait_idle(FRAME + 50, "t5_idle");
      flush_inv("t5");

      // Random bytes with bursty and sparse spacing.
      for (int n = 0; n < 40; n++) begin
         push(8'($urandom), ac);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 700)) @(posedge clk);
      end
      wait_idle(6 * FRAME, "rand_idle");
      repeat (5) @(posedge clk);
      flush_inv("rand");
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
